down_counter_ctrl: RTL and testbench
====================================

// Module: down_counter_ctrl
// PURPOSE
//  Command-driven sequencer for a WIDTH-bit down counter: accepts a countdown length over a
//  valid/ready handshake, runs the count to zero, then signals completion. Supports pause
//  and abort. Sits between a host/config block and timing consumers needing one-shot delays.
// PARAMETERS
//  WIDTH  4  width of cmd_len and count; max length 2**WIDTH-1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  cmd_valid  in   1      command request
//  cmd_ready  out  1      controller can accept a command
//  cmd_len    in   WIDTH  countdown length L, sampled on accept
//  pause      in   1      level; freezes count while high in RUN
//  abort      in   1      level; cancels an active countdown
//  count      out  WIDTH  current counter value (registered)
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle completion pulse (registered)
//  aborted    out  1      one-cycle abort acknowledge (registered)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, count=0, cmd_ready=1, busy=0, done=0, aborted=0.
//  FSM states IDLE, RUN, DONE; state, count, done, aborted are flops; cmd_ready=(state==IDLE).
//  IDLE: accept = cmd_valid & cmd_ready; on accept count<=cmd_len, len_q<=cmd_len;
//    L!=0 -> RUN; L==0 -> DONE. abort/pause ignored in IDLE (accept wins over abort).
//  RUN, per edge, priority order:
//    1 abort=1  -> IDLE, count<=0, aborted pulses 1 cycle, no done.
//    2 pause=1  -> stay RUN, count held.
//    3 count==1 -> count<=0, DONE.
//    4 else     -> count<=count-1.
//  DONE: done=1 for exactly one cycle, count=0, then IDLE (cmd_ready=1 next cycle).
//    abort in DONE ignored; cmd_valid not accepted in DONE.
//  Latency: done rises L unpaused RUN edges after accept edge (L=0: right after accept).
//    Each paused edge adds one cycle. Back-to-back commands: min period L+2 cycles.
//  count never underflows/wraps; decrement only from count>=2, 1->0 transition exits RUN.
//  cmd_len sampled only on accept; changes afterwards have no effect.
//  Reset asserted mid-run: immediate return to reset values, no done/aborted pulse.
// CONFIGURATION
//  TIMER_AUTO_RELOAD_EN defined: adds input cmd_reload (1 bit), sampled into reload_q on
//    accept. If reload_q=1, DONE -> RUN with count<=len_q (DONE -> DONE if len_q==0,
//    done held high continuously); done pulses every L+1 cycles until abort (abort also
//    honoured in DONE when reload_q=1: -> IDLE, aborted pulse, no done that cycle).
//    reload_q cleared on abort and on reset.
//  Not defined: no cmd_reload port, one-shot only, behaviour exactly as above.
// TESTING
//  1 Reset: rst_n=0 2 cycles -> count=0, cmd_ready=1, busy=0, done=0, aborted=0.
//  2 Accept L=5, pause=0 -> count 5,4,3,2,1,0 on successive edges; done=1 one cycle at
//    count=0; cmd_ready=1 next cycle.
//  3 L=6, pause=1 for 3 cycles at count=3 -> count holds 3 for 3 edges; done 3 cycles late.
//  4 L=10, abort at count=4 -> next edge count=0, aborted=1 one cycle, done never asserts.
//  5 L=0 -> done=1 the cycle after accept; L=15 (max) -> reaches 0 without wrap, single done.
//  6 TIMER_AUTO_RELOAD_EN, L=3, cmd_reload=1 -> done every 4 cycles, count 3,2,1,0,3,...
//    until abort; async reset mid-run -> outputs return to reset values immediately.

Source files
------------

// File: rtl/down_counter_ctrl.sv
// Command-driven WIDTH-bit down counter with pause/abort and a one-cycle done pulse.
// Optional auto-reload mode is enabled by defining TIMER_AUTO_RELOAD_EN.
module down_counter_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_len,
    input  logic             pause,
    input  logic             abort,
`ifdef TIMER_AUTO_RELOAD_EN
    input  logic             cmd_reload,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_d;
    logic             done_d;
    logic             aborted_d;

`ifdef TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] len_q;
    logic [WIDTH-1:0] len_d;
    logic             reload_q;
    logic             reload_d;
`endif

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);

    // State, counter and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count    <= '0;
            done     <= 1'b0;
            aborted  <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
            len_q    <= '0;
            reload_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count    <= count_d;
            done     <= done_d;
            aborted  <= aborted_d;
`ifdef TIMER_AUTO_RELOAD_EN
            len_q    <= len_d;
            reload_q <= reload_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        count_d   = count;
        aborted_d = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
        len_d     = len_q;
        reload_d  = reload_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    count_d = cmd_len;
`ifdef TIMER_AUTO_RELOAD_EN
                    len_d    = cmd_len;
                    reload_d = cmd_reload;
`endif
                    state_d = (cmd_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    count_d   = '0;
                    aborted_d = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                    reload_d  = 1'b0;
`endif
                end else if (pause) begin
                    count_d = count;
                end else if (count <= WIDTH'(1)) begin
                    // 1 -> 0 leaves RUN; never decrement below zero
                    count_d = '0;
                    state_d = S_DONE;
                end else begin
                    count_d = count - WIDTH'(1);
                end
            end
            S_DONE: begin
                count_d = '0;
                state_d = S_IDLE;
`ifdef TIMER_AUTO_RELOAD_EN
                if (reload_q) begin
                    if (abort) begin
                        aborted_d = 1'b1;
                        reload_d  = 1'b0;
                    end else if (len_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        count_d = len_q;
                        state_d = S_RUN;
                    end
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
        // done is high for every cycle spent in DONE
        done_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Self-checking bench for down_counter_ctrl: vector table plus hand sequences,
// expected outputs queued at drive time and compared after each clock edge.
module tb_down_counter_ctrl;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_len;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             aborted;
`ifdef TIMER_AUTO_RELOAD_EN
    logic             cmd_reload;
`endif

    down_counter_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .pause     (pause),
        .abort     (abort),
`ifdef TIMER_AUTO_RELOAD_EN
        .cmd_reload(cmd_reload),
`endif
        .count     (count),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] len;
        logic             p;
        logic             a;
        logic [WIDTH-1:0] cnt;
        logic             dn;
        logic             ab;
        logic             bz;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] cnt;
        logic             dn;
        logic             ab;
        logic             bz;
    } exp_t;

    vec_t  vecs[$];
    exp_t  sb_q[$];
    int    total = 0;
    int    bad   = 0;
    int    idx   = 0;
    int    done_seen;
    string tag   = "reset";

    function automatic void add(input logic v, input int len, input logic p, input logic a,
                                input int cnt, input logic dn, input logic ab, input logic bz);
        vec_t x;
        x.v = v; x.len = WIDTH'(len); x.p = p; x.a = a;
        x.cnt = WIDTH'(cnt); x.dn = dn; x.ab = ab; x.bz = bz;
        vecs.push_back(x);
    endfunction

    task automatic check(input exp_t e);
        total++;
        idx++;
        if ({count, done, aborted, cmd_ready, busy} !== {e.cnt, e.dn, e.ab, ~e.bz, e.bz}) begin
            bad++;
            $display("FAIL %s #%0d: got count=%0d done=%b aborted=%b ready=%b busy=%b, want count=%0d done=%b aborted=%b ready=%b busy=%b",
                     tag, idx, count, done, aborted, cmd_ready, busy,
                     e.cnt, e.dn, e.ab, ~e.bz, e.bz);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge
    task automatic step(input logic v, input int len, input logic p, input logic a,
                        input int cnt, input logic dn, input logic ab, input logic bz);
        exp_t e;
        cmd_valid = v;
        cmd_len   = WIDTH'(len);
        pause     = p;
        abort     = a;
        e.cnt = WIDTH'(cnt); e.dn = dn; e.ab = ab; e.bz = bz;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got count=%0d want an entry", tag, count);
        end else begin
            e = sb_q.pop_front();
            check(e);
            if (done) done_seen++;
        end
    endtask

    initial begin
        exp_t rst_e;
        rst_e.cnt = '0; rst_e.dn = 1'b0; rst_e.ab = 1'b0; rst_e.bz = 1'b0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; pause = 1'b0; abort = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
        cmd_reload = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check(rst_e);
        rst_n = 1'b1;

        // L=5 straight run; cmd_valid during DONE is not accepted
        add(1, 5, 0, 0, 5, 0, 0, 1);
        add(0, 0, 0, 0, 4, 0, 0, 1);
        add(0, 0, 0, 0, 3, 0, 0, 1);
        add(0, 0, 0, 0, 2, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 1);
        add(1, 7, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // L=6 with a three-edge pause at count 3
        add(1, 6, 0, 0, 6, 0, 0, 1);
        add(0, 0, 0, 0, 5, 0, 0, 1);
        add(0, 0, 0, 0, 4, 0, 0, 1);
        add(0, 0, 0, 0, 3, 0, 0, 1);
        add(0, 0, 1, 0, 3, 0, 0, 1);
        add(0, 0, 1, 0, 3, 0, 0, 1);
        add(0, 0, 1, 0, 3, 0, 0, 1);
        add(0, 0, 0, 0, 2, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // L=10 aborted at count 4
        add(1, 10, 0, 0, 10, 0, 0, 1);
        add(0, 0, 0, 0, 9, 0, 0, 1);
        add(0, 0, 0, 0, 8, 0, 0, 1);
        add(0, 0, 0, 0, 7, 0, 0, 1);
        add(0, 0, 0, 0, 6, 0, 0, 1);
        add(0, 0, 0, 0, 5, 0, 0, 1);
        add(0, 0, 0, 0, 4, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // accept beats abort in IDLE; abort ignored in DONE
        add(1, 2, 0, 1, 2, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        // abort beats pause in RUN
        add(1, 3, 0, 0, 3, 0, 0, 1);
        add(0, 0, 1, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // L=0 completes right after accept; pause ignored in IDLE
        add(1, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // pause at count 1, and cmd_len changing after accept
        add(1, 2, 0, 0, 2, 0, 0, 1);
        add(0, 9, 0, 0, 1, 0, 0, 1);
        add(0, 9, 1, 0, 1, 0, 0, 1);
        add(0, 9, 0, 0, 0, 1, 0, 1);
        add(0, 9, 0, 0, 0, 0, 0, 0);

        tag = "table";
        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].v, int'(vecs[i].len), vecs[i].p, vecs[i].a,
                 int'(vecs[i].cnt), vecs[i].dn, vecs[i].ab, vecs[i].bz);

        // L=15: full-range countdown, no wrap, exactly one done
        tag = "max_len";
        done_seen = 0;
        step(1, 15, 0, 0, 15, 0, 0, 1);
        for (int c = 14; c >= 1; c--)
            step(0, 0, 0, 0, c, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (done_seen != 1) begin
            bad++;
            $display("FAIL max_len_done_count: got %0d pulses want 1", done_seen);
        end

`ifdef TIMER_AUTO_RELOAD_EN
        // L=3 auto-reload: done every 4 cycles until abort
        tag = "reload";
        cmd_reload = 1'b1;
        step(1, 3, 0, 0, 3, 0, 0, 1);
        cmd_reload = 1'b0;
        for (int r = 0; r < 2; r++) begin
            step(0, 0, 0, 0, 2, 0, 0, 1);
            step(0, 0, 0, 0, 1, 0, 0, 1);
            step(0, 0, 0, 0, 0, 1, 0, 1);
            step(0, 0, 0, 0, 3, 0, 0, 1);
        end
        step(0, 0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // abort honoured in DONE when reloading
        tag = "reload_done_abort";
        cmd_reload = 1'b1;
        step(1, 2, 0, 0, 2, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 0, 1, 0);
        // L=0 reload holds done high
        tag = "reload_zero";
        step(1, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 0, 1, 0);
        cmd_reload = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0);
`endif

        // asynchronous reset mid-run takes effect without a clock edge
        tag = "async_reset";
        step(1, 8, 0, 0, 8, 0, 0, 1);
        step(0, 0, 0, 0, 7, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check(rst_e);
        @(posedge clk);
        #1;
        check(rst_e);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
